// File: rtl/gf_pkg.sv
// Shared constants and helpers for the shared GF/integer multiplier scheduler.
// Mode encodings match the gf_option input of the multiplier core.
package gf_pkg;

    localparam logic GF_OP_INT   = 1'b1;
    localparam logic GF_OP_CLMUL = 1'b0;

    // Minimum of 1 so a single-bit ID is still legal for small requester counts.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_rca_mult_bis.sv
// Shift-and-add array multiplier sharing one ripple-carry chain for both modes.
// In carry-less mode the carries are forced to zero, leaving a pure XOR accumulate.
module gf_rca_mult_bis
    import gf_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           gf_option,
    output logic [2*W-1:0] out
);

    logic w_carry_en;
    assign w_carry_en = (gf_option == GF_OP_INT);

    always_comb begin
        logic [2*W-1:0] acc;
        logic [2*W-1:0] pp;
        logic [2*W-1:0] sum;
        logic           c;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            pp  = b[i] ? ({{W{1'b0}}, a} << i) : '0;
            sum = '0;
            c   = 1'b0;
            for (int j = 0; j < 2*W; j++) begin
                sum[j] = acc[j] ^ pp[j] ^ c;
                c      = w_carry_en & ((acc[j] & pp[j]) | (c & (acc[j] ^ pp[j])));
            end
            acc = sum;
        end
        out = acc;
    end

endmodule

// File: rtl/gf_rr_arbiter.sv
// Round-robin requester select: first asserted request at or after ptr, wrapping.
// grant is gated by en; grant_idx is valid whenever any request is present.
module gf_rr_arbiter
    import gf_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        int idx;
        w_found   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!w_found && req[idx]) begin
                w_found   = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (w_found && en) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/gf_mult_rr_sched.sv
// Round-robin front end sharing one GF/integer multiplier between NUM_REQ requesters.
// Two stages: operand register feeding the multiplier, then the result register.
module gf_mult_rr_sched
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_gf_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_gf_op,
    output logic [2*DATA_WIDTH-1:0]       rsp_out,
    output logic [1:0]                    inflight
);

    logic                    r_s1_v;
    logic                    r_s1_op;
    logic [DATA_WIDTH-1:0]   r_s1_a;
    logic [DATA_WIDTH-1:0]   r_s1_b;
    logic [ID_W-1:0]         r_s1_id;

    logic                    r_s2_v;
    logic                    r_s2_op;
    logic [ID_W-1:0]         r_s2_id;
    logic [2*DATA_WIDTH-1:0] r_s2_out;

    logic [ID_W-1:0]         r_rr_ptr;

    logic                    w_s1_adv;
    logic                    w_s2_adv;
    logic                    w_accept;
    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_grant_idx;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_s2_adv = !r_s2_v || rsp_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    // Ready never depends on itself: only on valids, pointer and registered stage state.
    gf_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .en        (w_s1_adv && !rst),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    gf_rca_mult_bis #(
        .W (DATA_WIDTH)
    ) u_mult (
        .a         (r_s1_a),
        .b         (r_s1_b),
        .gf_option (r_s1_op),
        .out       (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s2_op  <= 1'b0;
            r_s2_id  <= '0;
            r_s2_out <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_s1_adv) r_s1_v <= w_accept;
            if (w_s2_adv) r_s2_v <= r_s1_v;
            if (r_s1_v && w_s2_adv) begin
                r_s2_op  <= r_s1_op;
                r_s2_id  <= r_s1_id;
                r_s2_out <= w_prod;
            end
        end
    end

    // Operand stage only matters while r_s1_v is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a  <= req_a[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_s1_b  <= req_b[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_s1_op <= req_gf_op[w_grant_idx];
            r_s1_id <= w_grant_idx;
        end
    end

    assign rsp_valid = r_s2_v;
    assign rsp_id    = r_s2_id;
    assign rsp_gf_op = r_s2_op;
    assign rsp_out   = r_s2_out;
    assign inflight  = {1'b0, r_s1_v} + {1'b0, r_s2_v};

endmodule

// File: tb/tb_gf_mult_rr_sched.sv
// Bench for gf_mult_rr_sched: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_gf_mult_rr_sched;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_gf_op;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic              rsp_gf_op;
    logic [2*DW-1:0]   rsp_out;
    logic [1:0]        inflight;

    gf_mult_rr_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_gf_op (req_gf_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gf_op (rsp_gf_op),
        .rsp_out   (rsp_out),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int              id;
        bit              op;
        logic [2*DW-1:0] prod;
        int              acc_cyc;
    } txn_t;

    txn_t          q[$];
    int            m_ptr = 0;
    logic [NR-1:0] acc_mask = '0;
    txn_t          rsp_log[$];
    int            dut_grants[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain arithmetic for integer mode, XOR of shifted copies for carry-less mode.
    function automatic logic [2*DW-1:0] ref_mult(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input bit op);
        logic [2*DW-1:0] r;
        if (op) return (2*DW)'(a) * (2*DW)'(b);
        r = '0;
        for (int i = 0; i < DW; i++) if (b[i]) r ^= (2*DW)'(a) << i;
        return r;
    endfunction

    // Reference model: in-order queue, a result is visible two cycles after acceptance,
    // and at most two requests may be held once this cycle's departure is accounted for.
    always @(negedge clk) begin
        int            occ;
        int            g;
        int            idx;
        bit            exp_v;
        bit            fire;
        logic [NR-1:0] exp_ready;
        txn_t          t;
        cyc++;
        if (rst) begin
            chk("ready_in_reset", req_ready, '0);
            q.delete();
            m_ptr    = 0;
            acc_mask = '0;
        end else begin
            exp_v = (q.size() > 0) && (cyc - q[0].acc_cyc >= 2);
            chk("rsp_valid", rsp_valid, exp_v);
            chk("inflight", inflight, q.size());
            if (exp_v) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_gf_op", rsp_gf_op, q[0].op);
                chk("rsp_out", rsp_out, q[0].prod);
            end
            fire = exp_v && rsp_ready;
            occ  = q.size() - (fire ? 1 : 0);
            g    = -1;
            if (occ < 2) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);

            acc_mask = req_valid & req_ready;
            for (int i = 0; i < NR; i++) if (acc_mask[i]) dut_grants.push_back(i);
            if (rsp_valid && rsp_ready) begin
                t.id = int'(rsp_id); t.op = rsp_gf_op; t.prod = rsp_out; t.acc_cyc = cyc;
                rsp_log.push_back(t);
            end

            if (fire) void'(q.pop_front());
            if (g >= 0) begin
                t.id      = g;
                t.op      = req_gf_op[g];
                t.prod    = ref_mult(req_a[g*DW +: DW], req_b[g*DW +: DW], req_gf_op[g]);
                t.acc_cyc = cyc;
                q.push_back(t);
                m_ptr = (g + 1) % NR;
            end
        end
    end

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit op);
        req_valid[i]         = 1'b1;
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_gf_op[i]         = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        rsp_log.delete();
        dut_grants.delete();
    endtask

    task automatic wait_rsp(input int n, input string name);
        int t;
        t = 0;
        while (rsp_log.size() < n && t < 30) begin
            step();
            t++;
        end
        chk(name, rsp_log.size(), n);
    endtask

    task automatic run_one(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit op, input logic [2*DW-1:0] exp, input string name);
        rsp_log.delete();
        set_req(i, a, b, op);
        wait_rsp(1, {name, "_timeout"});
        if (rsp_log.size() > 0) begin
            chk({name, "_out"}, rsp_log[0].prod, exp);
            chk({name, "_id"}, rsp_log[0].id, i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_gf_op = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Pin the model against hand-computed products.
        chk("model_clmul", ref_mult(8'h53, 8'hCA, 1'b0), 16'h3F7E);
        chk("model_int", ref_mult(8'hFF, 8'hFF, 1'b1), 16'hFE01);

        do_reset();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_inflight", inflight, 2'd0);
        chk("reset_rsp_out", rsp_out, '0);
        chk("reset_rsp_id", rsp_id, '0);

        // Single requests in both modes.
        run_one(0, 8'h53, 8'hCA, 1'b0, 16'h3F7E, "t1_req0_clmul");
        run_one(1, 8'h53, 8'hCA, 1'b1, 16'h417E, "t2_req1_int");
        run_one(1, 8'hFF, 8'hFF, 1'b1, 16'hFE01, "t2_ff_int");
        run_one(1, 8'hFF, 8'hFF, 1'b0, 16'h5555, "t2_ff_clmul");

        // All four requesters continuously valid.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i])
                    set_req(i, DW'($urandom), DW'($urandom), 1'($urandom));
            step();
        end
        req_valid = '0;
        repeat (4) step();
        chk("t3_grant_count", (dut_grants.size() >= 8), 1'b1);
        if (dut_grants.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("t3_grant_order", dut_grants[k], k % NR);
        end
        chk("t3_rsp_count", (rsp_log.size() >= 6), 1'b1);
        if (rsp_log.size() >= 6) chk("t3_rsp_id4", rsp_log[4].id, 0);

        // Two accepts, then a five-cycle stall with a third request waiting.
        do_reset();
        set_req(0, 8'h03, 8'h07, 1'b1);
        set_req(1, 8'h03, 8'h07, 1'b0);
        step();
        step();
        rsp_ready = 1'b0;
        set_req(2, 8'h02, 8'h09, 1'b1);
        repeat (4) step();
        chk("t4_stall_inflight", inflight, 2'd2);
        chk("t4_stall_ready", req_ready, 4'b0000);
        chk("t4_stall_id", rsp_id, 2'd0);
        chk("t4_stall_out", rsp_out, 16'h0015);
        step();
        rsp_ready = 1'b1;
        #1;
        chk("t4_release_ready", req_ready, 4'b0100);
        wait_rsp(3, "t4_drain");
        if (rsp_log.size() >= 3) begin
            chk("t4_order0", {rsp_log[0].id, 32'(rsp_log[0].prod)}, {32'd0, 32'h15});
            chk("t4_order1", {rsp_log[1].id, 32'(rsp_log[1].prod)}, {32'd1, 32'h09});
            chk("t4_order2", {rsp_log[2].id, 32'(rsp_log[2].prod)}, {32'd2, 32'h12});
        end

        // Pointer at 2 after serving requester 1; requesters 0 and 3 contend.
        do_reset();
        set_req(1, 8'h11, 8'h22, 1'b1);
        wait_rsp(1, "t5_setup");
        dut_grants.delete();
        set_req(0, 8'h05, 8'h06, 1'b1);
        set_req(3, 8'h07, 8'h08, 1'b0);
        repeat (4) step();
        chk("t5_grant_count", dut_grants.size(), 2);
        if (dut_grants.size() >= 2) begin
            chk("t5_first", dut_grants[0], 3);
            chk("t5_second", dut_grants[1], 0);
        end

        // Reset with both stages full; pointer must return to zero.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 8'h12, 8'h34, 1'b1);
        set_req(1, 8'h56, 8'h78, 1'b0);
        step();
        step();
        chk("t6_pre_inflight", inflight, 2'd2);
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        chk("t6_post_rsp_valid", rsp_valid, 1'b0);
        chk("t6_post_inflight", inflight, 2'd0);
        rsp_ready = 1'b1;
        rsp_log.delete();
        dut_grants.delete();
        set_req(3, 8'h0A, 8'h0B, 1'b1);
        set_req(0, 8'h0C, 8'h0D, 1'b1);
        repeat (6) step();
        chk("t6_rsp_count", rsp_log.size(), 2);
        if (rsp_log.size() >= 2) begin
            chk("t6_first_id", rsp_log[0].id, 0);
            chk("t6_second_id", rsp_log[1].id, 3);
        end

        // Randomized soak with backpressure and occasional mid-flight resets.
        for (int c = 0; c < 1500; c++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, DW'($urandom), DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                rst       = 1'b1;
                req_valid = '0;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("final_inflight", inflight, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
